// File: rtl/gray_ptr_pkg.sv
// Shared constants and helpers for the Gray pointer receive path.
// Stage sizing and latency are derived here so the top and bench agree.
package gray_ptr_pkg;

    localparam int MAX_SYNC  = 4;
    localparam int MIN_WIDTH = 2;

    function automatic int f_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Edges from gray_in being sampled to the matching bin_out.
    function automatic int f_lat(input int sync_stages, input int dec_stages);
        return sync_stages + dec_stages;
    endfunction

    localparam int LAT_DEFAULT = f_lat(2, 2);

endpackage

// File: rtl/gray2bin_stage.sv
// One registered slice of the Gray-to-binary prefix-XOR chain.
// Resolves bits HI down to LO; a stage with HI < LO just passes its inputs through.
module gray2bin_stage #(
    parameter int W  = 8,
    parameter int HI = 7,
    parameter int LO = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] g_in,
    input  logic [W-1:0] b_in,
    input  logic         c_in,
    output logic [W-1:0] b_comb,
    output logic [W-1:0] g_out,
    output logic [W-1:0] b_out,
    output logic         c_out
);

    logic c_comb;

    // c_comb carries the binary value of the most recently resolved bit.
    always_comb begin
        b_comb = b_in;
        c_comb = c_in;
        for (int i = W - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
                c_comb    = c_comb ^ g_in[i];
                b_comb[i] = c_comb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_out <= '0;
            b_out <= '0;
            c_out <= 1'b0;
        end else begin
            g_out <= g_in;
            b_out <= b_comb;
            c_out <= c_comb;
        end
    end

endmodule

// File: rtl/gray_ptr_decoder.sv
// Receive side of a Gray pointer crossing: synchroniser, pipelined decode,
// fill level against the local read pointer and a sticky illegal-step flag.
module gray_ptr_decoder
    import gray_ptr_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 8,
    parameter int C_SYNC_STAGES = 2,
    parameter int C_DEC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_DATA_WIDTH-1:0] gray_in,
    input  logic [C_DATA_WIDTH-1:0] rd_ptr,
    input  logic                    err_clr,
    output logic [C_DATA_WIDTH-1:0] bin_out,
    output logic                    bin_vld,
    output logic [C_DATA_WIDTH-1:0] level,
    output logic                    step_err
);

    localparam int W   = C_DATA_WIDTH;
    localparam int K   = f_ceil_div(W, C_DEC_STAGES);
    localparam int LAT = f_lat(C_SYNC_STAGES, C_DEC_STAGES);
    localparam int CW  = $clog2(LAT + 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0]  sync_q [C_SYNC_STAGES];
    logic [W-1:0]  g_pipe [C_DEC_STAGES+1];
    logic [W-1:0]  b_pipe [C_DEC_STAGES+1];
    logic          c_pipe [C_DEC_STAGES+1];
    logic [W-1:0]  b_nxt  [C_DEC_STAGES];
    logic [W-1:0]  bin_final_nxt;
    logic [W-1:0]  delta;
    logic          step_set;
    logic [CW-1:0] cnt;

    // Plain flop chain: nothing but the raw Gray value crosses into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_pipe[0] = sync_q[C_SYNC_STAGES-1];
    assign b_pipe[0] = '0;
    assign c_pipe[0] = 1'b0;

    for (genvar s = 0; s < C_DEC_STAGES; s++) begin : g_stage
        localparam int HI = W - 1 - s * K;
        localparam int LO = (W - (s + 1) * K < 0) ? 0 : W - (s + 1) * K;
        gray2bin_stage #(.W(W), .HI(HI), .LO(LO)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .g_in   (g_pipe[s]),
            .b_in   (b_pipe[s]),
            .c_in   (c_pipe[s]),
            .b_comb (b_nxt[s]),
            .g_out  (g_pipe[s+1]),
            .b_out  (b_pipe[s+1]),
            .c_out  (c_pipe[s+1])
        );
    end

    assign bin_out       = b_pipe[C_DEC_STAGES];
    assign bin_final_nxt = b_nxt[C_DEC_STAGES-1];

    // Step compares the value about to land in bin_out with the one it replaces.
    assign delta    = bin_final_nxt - bin_out;
    assign step_set = bin_vld && (delta > ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bin_vld  <= 1'b0;
            level    <= '0;
            step_err <= 1'b0;
        end else begin
            if (cnt != CW'(LAT)) cnt <= cnt + CW'(1);
            if (cnt == CW'(LAT - 1)) bin_vld <= 1'b1;
            level    <= bin_final_nxt - rd_ptr;
            step_err <= step_set | (step_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Directed bench for gray_ptr_decoder: driver queues expected binary pointers,
// monitor pops them whenever bin_vld is high and checks level and step_err too.
module tb_gray_ptr_decoder;

    localparam int W   = 8;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] rd_ptr = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] bin_out;
    logic         bin_vld;
    logic [W-1:0] level;
    logic         step_err;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    gray_ptr_decoder #(
        .C_DATA_WIDTH (W),
        .C_SYNC_STAGES(2),
        .C_DEC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .rd_ptr  (rd_ptr),
        .err_clr (err_clr),
        .bin_out (bin_out),
        .bin_vld (bin_vld),
        .level   (level),
        .step_err(step_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one input vector per cycle, given as the binary pointer value
    task automatic cyc(input logic [W-1:0] b, input logic [W-1:0] rd,
                       input logic clr, input logic r);
        @(negedge clk);
        gray_in = b ^ (b >> 1);
        rd_ptr  = rd;
        err_clr = clr;
        rst     = r;
        if (r) exp_q.delete();
        else   exp_q.push_back(b);
    endtask

    // monitor / scoreboard
    initial begin : monitor
        int           vcnt;
        logic         exp_err;
        logic         prev_ok;
        logic [W-1:0] prev_b;
        logic [W-1:0] eb;
        logic [W-1:0] d;
        vcnt = 0; exp_err = 1'b0; prev_ok = 1'b0; prev_b = '0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (rst) begin
                vcnt = 0; exp_err = 1'b0; prev_ok = 1'b0;
                chk("rst_bin_out", bin_out, '0);
                chk("rst_level", level, '0);
                chk("rst_bin_vld", W'(bin_vld), '0);
                chk("rst_step_err", W'(step_err), '0);
            end else begin
                if (vcnt < LAT) vcnt++;
                chk("bin_vld", W'(bin_vld), W'(vcnt == LAT));
                if (bin_vld) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard_empty: got output 0x%0h expected none", bin_out);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("bin_out", bin_out, eb);
                        chk("level", level, eb - rd_ptr);
                        d = eb - prev_b;
                        if (prev_ok && d > 8'd1) exp_err = 1'b1;
                        else if (err_clr)        exp_err = 1'b0;
                        chk("step_err", W'(step_err), W'(exp_err));
                        prev_b  = eb;
                        prev_ok = 1'b1;
                    end
                end else begin
                    prev_ok = 1'b0;
                    if (err_clr) exp_err = 1'b0;
                end
            end
        end
    end

    // stimulus
    initial begin
        repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b1);
        // bin_vld rises on the 4th edge after release, with bin_out 0
        repeat (6) cyc(8'h00, 8'h00, 1'b0, 1'b0);
        // full count-up 0..255 then wrap to 0
        for (int i = 0; i < 256; i++) cyc(W'(i), 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        // gray 0x80 = bin 0xFF: full against 0x7F, empty against 0xFF
        repeat (6) cyc(8'hFF, 8'h7F, 1'b0, 1'b0);
        repeat (6) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (4) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        // clean restart, then illegal jump 0 -> 4, clear, jump to 0x0A with clear on the same edge
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b1);
        repeat (6) cyc(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (6) cyc(8'h04, 8'h00, 1'b0, 1'b0);
        cyc(8'h04, 8'h00, 1'b1, 1'b0);
        repeat (3) cyc(8'h04, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc(8'h0A, 8'h00, 1'b0, 1'b0);
        cyc(8'h0A, 8'h00, 1'b1, 1'b0);
        repeat (3) cyc(8'h0A, 8'h00, 1'b0, 1'b0);
        // reset lands while bin_out shows 0x37
        for (int k = 0; k < 16; k++)
            cyc(8'h30 + W'(k), 8'h10, 1'b0, (k == 11 || k == 12));
        repeat (8) cyc(8'h40, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
